// File: rtl/ca_row_engine.sv
// Cellular-automaton row sequencer that owns port B of the frame buffer.
// Computes Wolfram-rule generations in place over a circular stack of rows.
module ca_row_engine #(
    parameter int unsigned WORDS_PER_ROW = 40,
    parameter int unsigned NUM_ROWS      = 204,
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned ROW_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              init,
    input  logic [7:0]        rule,
    output logic              busy,
    output logic              done,
    output logic [ROW_W-1:0]  newest_row,
    output logic [15:0]       gen_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    localparam int unsigned       Total    = NUM_ROWS * WORDS_PER_ROW;
    localparam logic [ADDR_W-1:0] WLast    = ADDR_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] WStop    = ADDR_W'(WORDS_PER_ROW - 2);
    localparam logic [ADDR_W-1:0] ClrLast  = ADDR_W'(Total - 1);
    localparam logic [ADDR_W-1:0] SeedAddr = ADDR_W'(WORDS_PER_ROW / 2);
    localparam logic [ADDR_W:0]   RowStep  = (ADDR_W + 1)'(WORDS_PER_ROW);
    localparam logic [ADDR_W:0]   WrapAt   = (ADDR_W + 1)'(Total);
    localparam logic [ROW_W-1:0]  RowLast  = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StFetchLast,
        StFetch0,
        StFetch1,
        StWrite,
        StRead,
        StWriteLast,
        StCommit,
        StClear,
        StSeed,
        StCommitInit
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d;
    logic [ROW_W-1:0]  newest_row_q, newest_row_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic [7:0]        rule_q, rule_d;
    logic              lbit_q, lbit_d;
    logic [15:0]       cur_q, cur_d;
    logic              first_msb_q, first_msb_d;

    logic [ADDR_W:0]   dst_sum;
    logic [ADDR_W-1:0] dst_base;

    assign dst_sum  = {1'b0, src_base_q} + RowStep;
    assign dst_base = (dst_sum >= WrapAt) ? '0 : dst_sum[ADDR_W-1:0];

    // Bit 15 is the leftmost pixel; l/rt are the neighbours just outside the word.
    function automatic logic [15:0] apply_rule(input logic [7:0] r, input logic l,
                                               input logic [15:0] c, input logic rt);
        logic [17:0] ext;
        logic [15:0] res;
        ext = {l, c, rt};
        res = '0;
        for (int b = 0; b < 16; b++) begin
            res[b] = r[ext[b+2 -: 3]];
        end
        return res;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        src_base_d   = src_base_q;
        newest_row_d = newest_row_q;
        gen_count_d  = gen_count_q;
        rule_d       = rule_q;
        lbit_d       = lbit_q;
        cur_d        = cur_q;
        first_msb_d  = first_msb_q;
        busy         = 1'b1;
        done         = 1'b0;
        mem_addr     = '0;
        mem_load     = 1'b0;
        mem_wdata    = '0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (init) begin
                    cnt_d   = '0;
                    state_d = StClear;
                end else if (start) begin
                    rule_d  = rule;
                    state_d = StFetchLast;
                end
            end
            StFetchLast: begin
                mem_addr = src_base_q + WLast;
                state_d  = StFetch0;
            end
            StFetch0: begin
                mem_addr = src_base_q;
                lbit_d   = mem_rdata[0];
                state_d  = StFetch1;
            end
            StFetch1: begin
                mem_addr    = src_base_q + 1'b1;
                cur_d       = mem_rdata;
                first_msb_d = mem_rdata[15];
                cnt_d       = '0;
                state_d     = StWrite;
            end
            StWrite: begin
                mem_addr  = dst_base + cnt_q;
                mem_load  = 1'b1;
                mem_wdata = apply_rule(rule_q, lbit_q, cur_q, mem_rdata[15]);
                lbit_d    = cur_q[0];
                cur_d     = mem_rdata;
                cnt_d     = cnt_q + 1'b1;
                state_d   = (cnt_q == WStop) ? StWriteLast : StRead;
            end
            StRead: begin
                mem_addr = src_base_q + cnt_q + 1'b1;
                state_d  = StWrite;
            end
            StWriteLast: begin
                mem_addr  = dst_base + WLast;
                mem_load  = 1'b1;
                mem_wdata = apply_rule(rule_q, lbit_q, cur_q, first_msb_q);
                state_d   = StCommit;
            end
            StCommit: begin
                done         = 1'b1;
                newest_row_d = (newest_row_q == RowLast) ? '0 : newest_row_q + 1'b1;
                src_base_d   = dst_base;
                gen_count_d  = gen_count_q + 16'd1;
                state_d      = StIdle;
            end
            StClear: begin
                mem_addr = cnt_q;
                mem_load = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == ClrLast) begin
                    state_d = StSeed;
                end
            end
            StSeed: begin
                mem_addr  = SeedAddr;
                mem_load  = 1'b1;
                mem_wdata = 16'h8000;
                state_d   = StCommitInit;
            end
            StCommitInit: begin
                done         = 1'b1;
                newest_row_d = '0;
                src_base_d   = '0;
                gen_count_d  = '0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            src_base_q   <= '0;
            newest_row_q <= '0;
            gen_count_q  <= '0;
            rule_q       <= '0;
            lbit_q       <= 1'b0;
            cur_q        <= '0;
            first_msb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            src_base_q   <= src_base_d;
            newest_row_q <= newest_row_d;
            gen_count_q  <= gen_count_d;
            rule_q       <= rule_d;
            lbit_q       <= lbit_d;
            cur_q        <= cur_d;
            first_msb_q  <= first_msb_d;
        end
    end

    assign newest_row = newest_row_q;
    assign gen_count  = gen_count_q;

endmodule
